mandelbrot_iterator: RTL and testbench

MANDELBROT_ITERATOR -- requirements
Module: mandelbrot_iterator

---
 rtl/mandelbrot_iterator_if.sv | 35 +++
 rtl/mandelbrot_iterator.sv | 110 +++++++++++
 tb/tb_mandelbrot_iterator.sv | 197 +++++++++++++++++++
 3 files changed

// File: rtl/mandelbrot_iterator_if.sv
// Point request, generator loop and result signals of the Mandelbrot iterator.
// The slave side is the iterator, the master side supplies points and the external z^2 generator.
interface mandelbrot_iterator_if #(
    parameter int ITER_W = 16
);
    logic              start;
    logic [31:0]       c_re;
    logic [31:0]       c_im;
    logic [ITER_W-1:0] max_iter;

    logic [31:0]       gen_a;
    logic [31:0]       gen_b;
    logic [31:0]       gen_aa_minus_bb;
    logic [31:0]       gen_two_ab;
    logic [31:0]       gen_aa_plus_bb;

    logic              busy;
    logic              done;
    logic [ITER_W-1:0] iter_count;
    logic              escaped;

    modport slave (
        input  start, c_re, c_im, max_iter,
        input  gen_aa_minus_bb, gen_two_ab, gen_aa_plus_bb,
        output gen_a, gen_b,
        output busy, done, iter_count, escaped
    );

    modport master (
        output start, c_re, c_im, max_iter,
        output gen_aa_minus_bb, gen_two_ab, gen_aa_plus_bb,
        input  gen_a, gen_b,
        input  busy, done, iter_count, escaped
    );
endinterface

// File: rtl/mandelbrot_iterator.sv
// Escape-time iterator for one point c in Q4.28: z <- z^2 + c, one step per clock,
// using an external combinational squarer that sees z on gen_a/gen_b.
module mandelbrot_iterator #(
    parameter int ITER_W = 16
) (
    input  logic                   clk,
    input  logic                   rst_n,
    mandelbrot_iterator_if.slave   bus
);
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ITER = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic signed [31:0] BOUND_POS = 32'sh2000_0000;   //  2.0
    localparam logic signed [31:0] BOUND_NEG = 32'shE000_0000;   // -2.0
    localparam logic signed [31:0] MAG_LIM   = 32'sh4000_0000;   //  4.0

    state_t             state_q;
    logic signed [31:0] z_re_q;
    logic signed [31:0] z_im_q;
    logic [31:0]        c_re_q;
    logic [31:0]        c_im_q;
    logic [ITER_W-1:0]  max_iter_q;
    logic [ITER_W-1:0]  n_q;
    logic               busy_q;
    logic               done_q;
    logic               escaped_q;
    logic [ITER_W-1:0]  iter_count_q;

    logic signed [31:0] z_re_d;
    logic signed [31:0] z_im_d;
    logic [ITER_W-1:0]  n_d;
    logic signed [31:0] mag_sq;
    logic               escape_hit;
    logic               limit_hit;

    // A negative |z|^2 can only come from generator overflow, so it is treated as divergence.
    always_comb begin
        mag_sq     = $signed(bus.gen_aa_plus_bb);
        escape_hit = (z_re_q > BOUND_POS) || (z_re_q < BOUND_NEG) ||
                     (z_im_q > BOUND_POS) || (z_im_q < BOUND_NEG) ||
                     (mag_sq > MAG_LIM)   || mag_sq[31];
        limit_hit  = (n_q == max_iter_q);
        z_re_d     = $signed(bus.gen_aa_minus_bb + c_re_q);
        z_im_d     = $signed(bus.gen_two_ab + c_im_q);
        n_d        = n_q + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            z_re_q       <= '0;
            z_im_q       <= '0;
            c_re_q       <= '0;
            c_im_q       <= '0;
            max_iter_q   <= '0;
            n_q          <= '0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            escaped_q    <= 1'b0;
            iter_count_q <= '0;
        end else begin
            case (state_q)
                IDLE, DONE: begin
                    done_q <= 1'b0;
                    if (bus.start) begin
                        state_q      <= ITER;
                        c_re_q       <= bus.c_re;
                        c_im_q       <= bus.c_im;
                        max_iter_q   <= bus.max_iter;
                        z_re_q       <= '0;
                        z_im_q       <= '0;
                        n_q          <= '0;
                        busy_q       <= 1'b1;
                        escaped_q    <= 1'b0;
                        iter_count_q <= '0;
                    end
                end
                ITER: begin
                    // Escape outranks the limit so a point diverging on its last step reports escaped.
                    if (escape_hit || limit_hit) begin
                        state_q      <= DONE;
                        busy_q       <= 1'b0;
                        done_q       <= 1'b1;
                        escaped_q    <= escape_hit;
                        iter_count_q <= n_q;
                    end else begin
                        z_re_q <= z_re_d;
                        z_im_q <= z_im_d;
                        n_q    <= n_d;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.gen_a      = z_re_q;
    assign bus.gen_b      = z_im_q;
    assign bus.busy       = busy_q;
    assign bus.done       = done_q;
    assign bus.escaped    = escaped_q;
    assign bus.iter_count = iter_count_q;
endmodule

// File: tb/tb_mandelbrot_iterator.sv
// Directed-vector bench: the driver queues hand-computed results, a monitor checks each done pulse.
module tb_mandelbrot_iterator;
    logic clk;
    logic rst_n;
    int   cyc;
    int   checks;
    int   failures;
    int   busy_cnt;

    typedef struct {
        int iter;
        bit esc;
        int acc;
    } exp_t;

    exp_t exp_q[$];

    mandelbrot_iterator_if #(.ITER_W(16)) bus ();

    mandelbrot_iterator #(.ITER_W(16)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // Reference z^2 generator in Q4.28 fed from the DUT's z registers.
    logic signed [31:0] ga;
    logic signed [31:0] gb;
    logic signed [63:0] aa_w;
    logic signed [63:0] bb_w;
    logic signed [63:0] ab_w;
    logic signed [63:0] dif_w;
    logic signed [63:0] sum_w;

    assign ga = bus.gen_a;
    assign gb = bus.gen_b;

    always_comb begin
        aa_w  = ga * ga;
        bb_w  = gb * gb;
        ab_w  = ga * gb;
        dif_w = (aa_w - bb_w) >>> 28;
        sum_w = (aa_w + bb_w) >>> 28;
    end

    assign bus.gen_aa_minus_bb = dif_w[31:0];
    assign bus.gen_aa_plus_bb  = sum_w[31:0];
    assign bus.gen_two_ab      = 32'(ab_w >>> 27);

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor: every done pulse must match the oldest outstanding expectation.
    always @(negedge clk) begin
        exp_t e;
        if (!rst_n) begin
            busy_cnt = 0;
        end else begin
            if (bus.busy === 1'b1) busy_cnt++;
            if (bus.done === 1'b1) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_done: got done=1 expected no pulse (t=%0t)", $time);
                end else begin
                    e = exp_q.pop_front();
                    chk("iter_count", 64'(bus.iter_count), 64'(e.iter));
                    chk("escaped",    64'(bus.escaped),    64'(e.esc));
                    chk("done_latency", 64'(cyc - e.acc),  64'(e.iter + 1));
                    chk("busy_cycles",  64'(busy_cnt),     64'(e.iter + 1));
                    $display("point done: iter=%0d escaped=%0d latency=%0d", bus.iter_count, bus.escaped, cyc - e.acc);
                end
                busy_cnt = 0;
            end
        end
    end

    task automatic wait_drain();
        int t;
        t = 0;
        while (exp_q.size() != 0 && t < 2000) begin
            @(negedge clk);
            t++;
        end
        if (exp_q.size() != 0) begin
            checks++;
            failures++;
            $display("FAIL done_timeout: got no done within %0d cycles, expected a done pulse", t);
            exp_q.delete();
        end
    endtask

    task automatic issue(input logic [31:0] cr, input logic [31:0] ci, input logic [15:0] mi,
                         input int ei, input bit ee, input bit expect_done);
        exp_t e;
        @(negedge clk);
        bus.start    = 1'b1;
        bus.c_re     = cr;
        bus.c_im     = ci;
        bus.max_iter = mi;
        if (expect_done) begin
            e.iter = ei;
            e.esc  = ee;
            e.acc  = cyc + 1;
            exp_q.push_back(e);
        end
        @(negedge clk);
        bus.start = 1'b0;
    endtask

    task automatic run_point(input logic [31:0] cr, input logic [31:0] ci, input logic [15:0] mi,
                             input int ei, input bit ee);
        issue(cr, ci, mi, ei, ee, 1'b1);
        wait_drain();
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_busy"},    64'(bus.busy),       64'(0));
        chk({tag, "_done"},    64'(bus.done),       64'(0));
        chk({tag, "_escaped"}, 64'(bus.escaped),    64'(0));
        chk({tag, "_iter"},    64'(bus.iter_count), 64'(0));
        chk({tag, "_gen_a"},   64'(bus.gen_a),      64'(0));
        chk({tag, "_gen_b"},   64'(bus.gen_b),      64'(0));
    endtask

    initial begin
        checks       = 0;
        failures     = 0;
        busy_cnt     = 0;
        rst_n        = 1'b0;
        bus.start    = 1'b1;
        bus.c_re     = 32'h1000_0000;
        bus.c_im     = 32'h1000_0000;
        bus.max_iter = 16'd7;

        // Reset must win over a simultaneous start.
        repeat (3) @(negedge clk);
        chk_all_zero("reset");
        bus.start = 1'b0;
        rst_n     = 1'b1;

        run_point(32'h0000_0000, 32'h0000_0000, 16'd100, 100, 1'b0);
        run_point(32'h1000_0000, 32'h1000_0000, 16'd50,  2,   1'b1);
        run_point(32'hE000_0000, 32'h0000_0000, 16'd50,  50,  1'b0);
        run_point(32'h7000_0000, 32'h7000_0000, 16'd0,   0,   1'b0);
        run_point(32'h0800_0000, 32'h0000_0000, 16'd50,  5,   1'b1);
        run_point(32'h0800_0000, 32'h0000_0000, 16'd5,   5,   1'b1);
        run_point(32'h0800_0000, 32'h0000_0000, 16'd4,   4,   1'b0);
        run_point(32'h2800_0000, 32'h0000_0000, 16'd50,  1,   1'b1);
        run_point(32'hDC00_0000, 32'h0000_0000, 16'd50,  1,   1'b1);
        run_point(32'h1800_0000, 32'h1800_0000, 16'd50,  1,   1'b1);
        run_point(32'h0000_0000, 32'h1000_0000, 16'd10,  10,  1'b0);

        // A second start while iterating must not disturb the first point.
        issue(32'h0000_0000, 32'h0000_0000, 16'd20, 20, 1'b0, 1'b1);
        repeat (5) @(negedge clk);
        bus.start    = 1'b1;
        bus.c_re     = 32'h1800_0000;
        bus.c_im     = 32'h1800_0000;
        bus.max_iter = 16'd0;
        @(negedge clk);
        bus.start = 1'b0;
        wait_drain();

        // Reset mid-run discards the point: no done pulse, outputs back to zero.
        issue(32'h0000_0000, 32'h1000_0000, 16'd100, 0, 1'b0, 1'b0);
        repeat (10) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        chk_all_zero("midrst");
        rst_n = 1'b1;
        repeat (5) @(negedge clk);
        chk("midrst_idle_busy", 64'(bus.busy), 64'(0));

        run_point(32'h0800_0000, 32'h0000_0000, 16'd50, 5, 1'b1);

        // Results stay held while parked in DONE.
        repeat (3) @(negedge clk);
        chk("hold_iter",    64'(bus.iter_count), 64'(5));
        chk("hold_escaped", 64'(bus.escaped),    64'(1));
        chk("hold_done",    64'(bus.done),       64'(0));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
